apb0_cmd_master: RTL and testbench
==================================

// Module: apb0_cmd_master
// PURPOSE
//  APB4 initiator that turns a single-outstanding valid/ready command into one APB transfer
//  (SETUP then ACCESS) and returns the result on a valid/ready response channel.
//  Drives the root side of the apb0 leaf decoder: its o_root_* outputs feed the decoder's root
//  inputs, and it consumes the decoder's merged pready/pslverr/prdata.
//  Adds a wait-state timeout and an alignment check, so a hung slave or bad address never hangs
//  the requester.
// PARAMETERS
//  TIMEOUT_CNT  256  max ACCESS cycles before abort; 0 disables timeout
//  ALIGN_CHK    1    1: cmd addr[1:0]!=0 is rejected with error and no bus access
//  CNT_W        9    timeout counter width; must hold TIMEOUT_CNT
// PORTS
//  i_pclk          in   1   APB clock
//  i_presetn       in   1   asynchronous active-low reset
//  i_cmd_valid     in   1   command request
//  o_cmd_ready     out  1   command accepted when valid&ready
//  i_cmd_addr      in   32  byte address
//  i_cmd_write     in   1   1=write, 0=read
//  i_cmd_wdata     in   32  write data
//  i_cmd_wstrb     in   4   write byte strobes
//  i_cmd_prot      in   3   pprot value
//  o_rsp_valid     out  1   response available
//  i_rsp_ready     in   1   response consumed when valid&ready
//  o_rsp_rdata     out  32  read data; 0 for writes and errors
//  o_rsp_err       out  1   pslverr, timeout or misalignment
//  o_rsp_timeout   out  1   error cause was timeout
//  o_root_psel     out  1   APB psel
//  o_root_penable  out  1   APB penable
//  o_root_paddr    out  32  APB paddr
//  o_root_pwrite   out  1   APB pwrite
//  o_root_pwdata   out  32  APB pwdata
//  o_root_pstrb    out  4   APB pstrb
//  o_root_pprot    out  3   APB pprot
//  i_root_pready   in   1   APB pready
//  i_root_pslverr  in   1   APB pslverr
//  i_root_prdata   in   32  APB prdata
// BEHAVIOUR
//  Reset: FSM=IDLE; counter=0. Every output is 0, including o_cmd_ready.
//   A ready-enable flop sets o_cmd_ready one cycle after reset deassertion.
//  FSM IDLE->SETUP->ACCESS->RESP->IDLE. All outputs are registered or decoded from state
//   registers; there are no combinational paths from inputs to outputs.
//  IDLE: o_cmd_ready=1. On valid&ready, latch addr/write/wdata/prot; latch pstrb=write?wstrb:4'h0.
//   If ALIGN_CHK and addr[1:0]!=0: go to RESP with err=1, timeout=0, rdata=0, no psel.
//   Otherwise go to SETUP.
//  SETUP (1 cycle): psel=1, penable=0. Go to ACCESS.
//  ACCESS: psel=1, penable=1; counter increments each cycle.
//   pready=1: capture rdata=write?0:prdata and err=pslverr, then go to RESP.
//   Otherwise, if TIMEOUT_CNT!=0 and counter==TIMEOUT_CNT-1: abort to RESP with err=1,
//    timeout=1, rdata=0.
//   pready arriving in the timeout cycle wins: normal completion, timeout=0.
//  RESP: psel=penable=0; o_rsp_valid=1, payload held stable until i_rsp_ready. Then go to IDLE
//   and clear rsp_valid, err, timeout and counter.
//  Minimum latency: accept T0, SETUP T1, ACCESS+pready T2, rsp_valid T3. Max throughput is one
//   transfer per 4 cycles.
//  paddr/pwrite/pwdata/pstrb/pprot are stable from SETUP to the end of ACCESS. They keep their
//   last value in IDLE/RESP, which limits toggling.
//  psel and penable are never 1 outside SETUP/ACCESS. penable=1 implies psel=1.
//  The decoder flags an unmapped address as pready=1,pslverr=1 in the first ACCESS cycle; this
//   returns err=1, timeout=0.
//  Reset asserted mid-transfer: all outputs clear asynchronously. The in-flight command is
//   dropped and no response is produced.
//  i_cmd_* is ignored outside IDLE. A held i_cmd_valid is accepted only after the current
//   response handshake.
// TESTING
//  Write 0x4000_0010, data 0xA5A5_5A5A, strb 0xF, pready high in ACCESS -> psel 2 cycles,
//   penable 1 cycle, rsp_valid at T3, err=0, rdata=0.
//  Read 0x4000_0004, pready low 3 ACCESS cycles, prdata=0x1234_5678 -> ACCESS lasts 4 cycles;
//   pstrb=0; rdata=0x1234_5678, err=0.
//  Read to unmapped 0x5FFF_0000 (decoder returns pready=1,pslverr=1) -> err=1, timeout=0,
//   rdata=0.
//  TIMEOUT_CNT=8, pready held 0 -> psel drops after 8 ACCESS cycles; err=1, timeout=1.
//   Repeat with pready=1 in the 8th cycle -> normal completion.
//  Misaligned addr 0x4000_0002 with ALIGN_CHK=1 -> no psel pulse, rsp_valid next cycle, err=1.
//  Hold i_rsp_ready=0 for 5 cycles with i_cmd_valid high -> payload stable, o_cmd_ready=0.
//   Reset during ACCESS -> psel/penable/rsp_valid drop at once; o_cmd_ready returns 1 cycle
//   after release.

Source files
------------

// File: rtl/apb0_cmd_master.sv
// APB4 initiator: converts one valid/ready command into a single SETUP/ACCESS transfer
// and returns read data and error status on a valid/ready response channel.
module apb0_cmd_master #(
    parameter int TIMEOUT_CNT = 256,
    parameter int ALIGN_CHK   = 1,
    parameter int CNT_W       = 9
) (
    input  logic        i_pclk,
    input  logic        i_presetn,

    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd_addr,
    input  logic        i_cmd_write,
    input  logic [31:0] i_cmd_wdata,
    input  logic [3:0]  i_cmd_wstrb,
    input  logic [2:0]  i_cmd_prot,

    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,

    output logic        o_root_psel,
    output logic        o_root_penable,
    output logic [31:0] o_root_paddr,
    output logic        o_root_pwrite,
    output logic [31:0] o_root_pwdata,
    output logic [3:0]  o_root_pstrb,
    output logic [2:0]  o_root_pprot,
    input  logic        i_root_pready,
    input  logic        i_root_pslverr,
    input  logic [31:0] i_root_prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CNT == 0) ? 0 : TIMEOUT_CNT - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              rdy_en;

    logic [31:0]       paddr_q;
    logic              pwrite_q;
    logic [31:0]       pwdata_q;
    logic [3:0]        pstrb_q;
    logic [2:0]        pprot_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              timeout_q;

    logic              cmd_fire;
    logic              misaligned;
    logic              timeout_hit;
    logic              rsp_fire;

    // Keeps o_cmd_ready low for the first cycle after reset release.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cmd_fire    = 1'b0;
        misaligned  = 1'b0;
        timeout_hit = 1'b0;
        rsp_fire    = 1'b0;

        misaligned  = (ALIGN_CHK != 0) && (i_cmd_addr[1:0] != 2'b00);
        timeout_hit = (TIMEOUT_CNT != 0) && (cnt == TO_LAST);

        case (state)
            IDLE: begin
                cmd_fire = rdy_en && i_cmd_valid;
                if (cmd_fire) begin
                    next_state = misaligned ? RESP : SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                // A late pready in the timeout cycle still completes normally.
                if (i_root_pready || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_fire = i_rsp_ready;
                if (rsp_fire) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command latch, wait-state counter and response payload.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            cnt       <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                paddr_q  <= i_cmd_addr;
                pwrite_q <= i_cmd_write;
                pwdata_q <= i_cmd_wdata;
                pstrb_q  <= i_cmd_write ? i_cmd_wstrb : 4'h0;
                pprot_q  <= i_cmd_prot;
                cnt      <= '0;
                if (misaligned) begin
                    err_q     <= 1'b1;
                    timeout_q <= 1'b0;
                    rdata_q   <= '0;
                end
            end

            if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
                if (i_root_pready) begin
                    rdata_q   <= (pwrite_q || i_root_pslverr) ? 32'h0 : i_root_prdata;
                    err_q     <= i_root_pslverr;
                    timeout_q <= 1'b0;
                end else if (timeout_hit) begin
                    rdata_q   <= '0;
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end

            if (rsp_fire) begin
                err_q     <= 1'b0;
                timeout_q <= 1'b0;
                cnt       <= '0;
            end
        end
    end

    assign o_cmd_ready    = rdy_en && (state == IDLE);
    assign o_rsp_valid    = (state == RESP);
    assign o_rsp_rdata    = rdata_q;
    assign o_rsp_err      = err_q;
    assign o_rsp_timeout  = timeout_q;

    assign o_root_psel    = (state == SETUP) || (state == ACCESS);
    assign o_root_penable = (state == ACCESS);
    assign o_root_paddr   = paddr_q;
    assign o_root_pwrite  = pwrite_q;
    assign o_root_pwdata  = pwdata_q;
    assign o_root_pstrb   = pstrb_q;
    assign o_root_pprot   = pprot_q;

endmodule

// File: tb/tb_apb0_cmd_master.sv
// Directed bench for apb0_cmd_master: walks write, wait-state read, slave error,
// timeout, misalignment, response backpressure and mid-transfer reset.
module tb_apb0_cmd_master;

    logic        i_pclk = 1'b0;
    logic        i_presetn;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [31:0] i_cmd_addr;
    logic        i_cmd_write;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic [2:0]  i_cmd_prot;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_rsp_timeout;
    logic        o_root_psel;
    logic        o_root_penable;
    logic [31:0] o_root_paddr;
    logic        o_root_pwrite;
    logic [31:0] o_root_pwdata;
    logic [3:0]  o_root_pstrb;
    logic [2:0]  o_root_pprot;
    logic        i_root_pready;
    logic        i_root_pslverr;
    logic [31:0] i_root_prdata;

    int errors = 0;
    int checks = 0;

    apb0_cmd_master #(
        .TIMEOUT_CNT(8),
        .ALIGN_CHK  (1),
        .CNT_W      (9)
    ) dut (
        .i_pclk        (i_pclk),
        .i_presetn     (i_presetn),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_write   (i_cmd_write),
        .i_cmd_wdata   (i_cmd_wdata),
        .i_cmd_wstrb   (i_cmd_wstrb),
        .i_cmd_prot    (i_cmd_prot),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_rdata   (o_rsp_rdata),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_timeout (o_rsp_timeout),
        .o_root_psel   (o_root_psel),
        .o_root_penable(o_root_penable),
        .o_root_paddr  (o_root_paddr),
        .o_root_pwrite (o_root_pwrite),
        .o_root_pwdata (o_root_pwdata),
        .o_root_pstrb  (o_root_pstrb),
        .o_root_pprot  (o_root_pprot),
        .i_root_pready (i_root_pready),
        .i_root_pslverr(i_root_pslverr),
        .i_root_prdata (i_root_prdata)
    );

    always #5 i_pclk = ~i_pclk;

    task automatic tick();
        @(posedge i_pclk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_cmd(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic [2:0] prot);
        i_cmd_valid = 1'b1;
        i_cmd_addr  = addr;
        i_cmd_write = write;
        i_cmd_wdata = wdata;
        i_cmd_wstrb = wstrb;
        i_cmd_prot  = prot;
    endtask

    task automatic rsp_handshake(input string tag);
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check_out({tag, "_rsp_cleared"}, {31'b0, o_rsp_valid}, 32'd0);
        check_out({tag, "_ready_back"}, {31'b0, o_cmd_ready}, 32'd1);
    endtask

    // Guards against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_presetn      = 1'b0;
        i_cmd_valid    = 1'b0;
        i_cmd_addr     = '0;
        i_cmd_write    = 1'b0;
        i_cmd_wdata    = '0;
        i_cmd_wstrb    = '0;
        i_cmd_prot     = '0;
        i_rsp_ready    = 1'b0;
        i_root_pready  = 1'b0;
        i_root_pslverr = 1'b0;
        i_root_prdata  = '0;

        // Reset state
        tick();
        tick();
        check_out("rst_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
        check_out("rst_psel", {31'b0, o_root_psel}, 32'd0);
        check_out("rst_penable", {31'b0, o_root_penable}, 32'd0);
        check_out("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        check_out("rst_paddr", o_root_paddr, 32'h0);
        i_presetn = 1'b1;
        #1;
        check_out("rel_ready_low", {31'b0, o_cmd_ready}, 32'd0);
        tick();
        check_out("rel_ready_high", {31'b0, o_cmd_ready}, 32'd1);

        // Write with zero wait states
        $display("[TB] write 0x4000_0010");
        apply_cmd(32'h4000_0010, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'b010);
        i_root_pready = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        check_out("wr_setup_psel", {31'b0, o_root_psel}, 32'd1);
        check_out("wr_setup_penable", {31'b0, o_root_penable}, 32'd0);
        check_out("wr_setup_ready", {31'b0, o_cmd_ready}, 32'd0);
        check_out("wr_paddr", o_root_paddr, 32'h4000_0010);
        check_out("wr_pwrite", {31'b0, o_root_pwrite}, 32'd1);
        check_out("wr_pwdata", o_root_pwdata, 32'hA5A5_5A5A);
        check_out("wr_pstrb", {28'b0, o_root_pstrb}, 32'hF);
        check_out("wr_pprot", {29'b0, o_root_pprot}, 32'd2);
        tick();
        check_out("wr_access_psel", {31'b0, o_root_psel}, 32'd1);
        check_out("wr_access_penable", {31'b0, o_root_penable}, 32'd1);
        check_out("wr_access_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        tick();
        check_out("wr_resp_psel", {31'b0, o_root_psel}, 32'd0);
        check_out("wr_resp_valid", {31'b0, o_rsp_valid}, 32'd1);
        check_out("wr_resp_err", {31'b0, o_rsp_err}, 32'd0);
        check_out("wr_resp_rdata", o_rsp_rdata, 32'h0);
        rsp_handshake("wr");

        // Read with three wait states
        $display("[TB] read 0x4000_0004 with wait states");
        apply_cmd(32'h4000_0004, 1'b0, 32'h0, 4'hF, 3'b000);
        i_root_pready = 1'b0;
        i_root_prdata = 32'h1234_5678;
        tick();
        i_cmd_valid = 1'b0;
        check_out("rd_pstrb_zero", {28'b0, o_root_pstrb}, 32'h0);
        check_out("rd_pwrite", {31'b0, o_root_pwrite}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("rd_wait_penable", {31'b0, o_root_penable}, 32'd1);
        end
        tick();
        check_out("rd_access4_psel", {31'b0, o_root_psel}, 32'd1);
        check_out("rd_paddr_stable", o_root_paddr, 32'h4000_0004);
        i_root_pready = 1'b1;
        tick();
        check_out("rd_resp_valid", {31'b0, o_rsp_valid}, 32'd1);
        check_out("rd_resp_rdata", o_rsp_rdata, 32'h1234_5678);
        check_out("rd_resp_err", {31'b0, o_rsp_err}, 32'd0);
        rsp_handshake("rd");

        // Unmapped address: decoder answers pready+pslverr at once
        $display("[TB] unmapped read");
        apply_cmd(32'h5FFF_0000, 1'b0, 32'h0, 4'h0, 3'b000);
        i_root_pready  = 1'b1;
        i_root_pslverr = 1'b1;
        i_root_prdata  = 32'hDEAD_BEEF;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        tick();
        check_out("unm_resp_valid", {31'b0, o_rsp_valid}, 32'd1);
        check_out("unm_err", {31'b0, o_rsp_err}, 32'd1);
        check_out("unm_timeout", {31'b0, o_rsp_timeout}, 32'd0);
        check_out("unm_rdata", o_rsp_rdata, 32'h0);
        i_root_pslverr = 1'b0;
        rsp_handshake("unm");

        // Timeout after 8 ACCESS cycles
        $display("[TB] timeout");
        apply_cmd(32'h4000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
        i_root_pready = 1'b0;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check_out("to_access_psel", {31'b0, o_root_psel}, 32'd1);
        end
        tick();
        check_out("to_psel_dropped", {31'b0, o_root_psel}, 32'd0);
        check_out("to_resp_valid", {31'b0, o_rsp_valid}, 32'd1);
        check_out("to_err", {31'b0, o_rsp_err}, 32'd1);
        check_out("to_timeout", {31'b0, o_rsp_timeout}, 32'd1);
        check_out("to_rdata", o_rsp_rdata, 32'h0);
        rsp_handshake("to");
        check_out("to_err_cleared", {31'b0, o_rsp_err}, 32'd0);
        check_out("to_flag_cleared", {31'b0, o_rsp_timeout}, 32'd0);

        // pready in the 8th ACCESS cycle beats the timeout
        $display("[TB] pready in timeout cycle");
        apply_cmd(32'h4000_0024, 1'b0, 32'h0, 4'h0, 3'b000);
        i_root_prdata = 32'hCAFE_0008;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check_out("late_access8_penable", {31'b0, o_root_penable}, 32'd1);
        i_root_pready = 1'b1;
        tick();
        check_out("late_resp_valid", {31'b0, o_rsp_valid}, 32'd1);
        check_out("late_err", {31'b0, o_rsp_err}, 32'd0);
        check_out("late_timeout", {31'b0, o_rsp_timeout}, 32'd0);
        check_out("late_rdata", o_rsp_rdata, 32'hCAFE_0008);
        rsp_handshake("late");

        // Misaligned command never reaches the bus
        $display("[TB] misaligned write");
        apply_cmd(32'h4000_0002, 1'b1, 32'h1111_2222, 4'hF, 3'b000);
        tick();
        i_cmd_valid = 1'b0;
        check_out("mis_psel", {31'b0, o_root_psel}, 32'd0);
        check_out("mis_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
        check_out("mis_err", {31'b0, o_rsp_err}, 32'd1);
        check_out("mis_timeout", {31'b0, o_rsp_timeout}, 32'd0);
        rsp_handshake("mis");

        // Response backpressure with a held command
        $display("[TB] backpressure");
        apply_cmd(32'h4000_0030, 1'b0, 32'h0, 4'h0, 3'b001);
        i_root_pready = 1'b1;
        i_root_prdata = 32'h0BAD_F00D;
        tick();
        tick();
        tick();
        i_root_prdata = 32'h7777_7777;
        for (int i = 0; i < 5; i++) begin
            check_out("bp_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
            check_out("bp_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
            check_out("bp_rdata", o_rsp_rdata, 32'h0BAD_F00D);
            check_out("bp_psel", {31'b0, o_root_psel}, 32'd0);
            tick();
        end
        rsp_handshake("bp");
        tick();
        i_cmd_valid = 1'b0;
        i_root_pready = 1'b0;
        check_out("held_setup_psel", {31'b0, o_root_psel}, 32'd1);
        check_out("held_paddr", o_root_paddr, 32'h4000_0030);

        // Reset while in ACCESS drops the transfer
        $display("[TB] reset during ACCESS");
        tick();
        check_out("rstacc_penable", {31'b0, o_root_penable}, 32'd1);
        i_presetn = 1'b0;
        #1;
        check_out("rstacc_psel", {31'b0, o_root_psel}, 32'd0);
        check_out("rstacc_penable_low", {31'b0, o_root_penable}, 32'd0);
        check_out("rstacc_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        check_out("rstacc_cmd_ready", {31'b0, o_cmd_ready}, 32'd0);
        tick();
        i_presetn = 1'b1;
        #1;
        check_out("rstacc_rel_ready_low", {31'b0, o_cmd_ready}, 32'd0);
        tick();
        check_out("rstacc_rel_ready_high", {31'b0, o_cmd_ready}, 32'd1);
        tick();
        check_out("rstacc_no_rsp", {31'b0, o_rsp_valid}, 32'd0);
        check_out("rstacc_no_psel", {31'b0, o_root_psel}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
